// File: rtl/io_stream_checker.sv
// -----------------------------------------------------------------------------
// io_stream_checker
//
// Consumes the Host->Logic GLIP FIFO stream in the logic clock domain and
// checks it against an incrementing-counter pattern. A 16-bit LFSR can inject
// pseudo-random backpressure so that the upstream FIFO and clock-domain
// crossing see realistic flow control.
//
// Ports:
//   clk            logic clock, all state on the rising edge
//   rst            asynchronous active-high reset
//   fifo_in_data   Host->Logic data word
//   fifo_in_valid  data valid
//   fifo_in_ready  checker accepts a word this cycle
//   stall_en       enable LFSR-driven backpressure (~25% stall)
//   clear          synchronous clear of checker state and counters
//   locked         synchronised to the pattern (LOCKED or ERROR)
//   error          sticky mismatch flag (ERROR state)
//   idle           no transfer for IDLE_CYCLES consecutive cycles
//   word_count     accepted words checked (saturating)
//   error_count    mismatches detected (saturating)
//   first_err_exp  expected value at the first mismatch
//   first_err_rcv  received value at the first mismatch
// -----------------------------------------------------------------------------
module io_stream_checker #(
  parameter int          WIDTH       = 16,
  parameter int          CNT_WIDTH   = 32,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          IDLE_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     fifo_in_data,
  input  logic                 fifo_in_valid,
  output logic                 fifo_in_ready,
  input  logic                 stall_en,
  input  logic                 clear,
  output logic                 locked,
  output logic                 error,
  output logic                 idle,
  output logic [CNT_WIDTH-1:0] word_count,
  output logic [CNT_WIDTH-1:0] error_count,
  output logic [WIDTH-1:0]     first_err_exp,
  output logic [WIDTH-1:0]     first_err_rcv
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    LOCKED = 2'd1,
    ERROR  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]     DATA_ONE = WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [15:0]          IDLE_MAX = 16'(IDLE_CYCLES);

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // Pattern successor; wraps modulo 2^WIDTH so 0xFFFF -> 0x0000 is a match.
  function automatic logic [WIDTH-1:0] wrap_inc(input logic [WIDTH-1:0] v);
    return v + DATA_ONE;
  endfunction

  state_t               state_q,   state_nxt;
  logic [WIDTH-1:0]     exp_q,     exp_nxt;
  logic [CNT_WIDTH-1:0] word_q,    word_nxt;
  logic [CNT_WIDTH-1:0] errc_q,    errc_nxt;
  logic [WIDTH-1:0]     fexp_q,    fexp_nxt;
  logic [WIDTH-1:0]     frcv_q,    frcv_nxt;

  logic        rst_q;
  logic        stall_q;
  logic [15:0] lfsr_q;
  logic        lfsr_fb;
  logic [15:0] idle_cnt_q;
  logic        xfer;

  // ---------------------------------------------------------------------------
  // Flow control: ready stays low during reset and the first cycle after it.
  // ---------------------------------------------------------------------------
  assign fifo_in_ready = ~rst_q & ~stall_q;
  assign xfer          = fifo_in_valid & fifo_in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_q <= 1'b1;
    end else begin
      rst_q <= 1'b0;
    end
  end

  // Right-shifting Fibonacci form of taps 16,14,13,11: feedback from bits
  // 0,2,3,5 enters at bit 15. Runs every cycle and ignores clear so the
  // stall sequence only depends on time since reset.
  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q  <= LFSR_SEED;
      stall_q <= 1'b0;
    end else begin
      lfsr_q  <= {lfsr_fb, lfsr_q[15:1]};
      stall_q <= stall_en & (lfsr_q[1:0] == 2'b00);
    end
  end

  // ---------------------------------------------------------------------------
  // Checker next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state_q;
    exp_nxt   = exp_q;
    word_nxt  = word_q;
    errc_nxt  = errc_q;
    fexp_nxt  = fexp_q;
    frcv_nxt  = frcv_q;

    if (clear) begin
      // A word transferred alongside clear is consumed but deliberately
      // neither checked nor counted.
      state_nxt = HUNT;
      exp_nxt   = '0;
      word_nxt  = '0;
      errc_nxt  = '0;
      fexp_nxt  = '0;
      frcv_nxt  = '0;
    end else if (xfer) begin
      word_nxt = sat_inc(word_q);
      case (state_q)
        LOCKED, ERROR: begin
          if (fifo_in_data == exp_q) begin
            exp_nxt = wrap_inc(exp_q);
          end else begin
            // Only the very first mismatch since clear/reset is captured.
            if (errc_q == '0) begin
              fexp_nxt = exp_q;
              frcv_nxt = fifo_in_data;
            end
            errc_nxt  = sat_inc(errc_q);
            exp_nxt   = wrap_inc(fifo_in_data);
            state_nxt = ERROR;
          end
        end
        default: begin
          // HUNT (and any unreachable encoding): adopt the stream as-is.
          exp_nxt   = wrap_inc(fifo_in_data);
          state_nxt = LOCKED;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Register stage: checker state and status counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      exp_q   <= '0;
      word_q  <= '0;
      errc_q  <= '0;
      fexp_q  <= '0;
      frcv_q  <= '0;
    end else begin
      state_q <= state_nxt;
      exp_q   <= exp_nxt;
      word_q  <= word_nxt;
      errc_q  <= errc_nxt;
      fexp_q  <= fexp_nxt;
      frcv_q  <= frcv_nxt;
    end
  end

  // Idle counter saturates at IDLE_CYCLES so idle holds until the next
  // transfer or clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt_q <= '0;
    end else if (xfer || clear) begin
      idle_cnt_q <= '0;
    end else if (idle_cnt_q != IDLE_MAX) begin
      idle_cnt_q <= idle_cnt_q + 16'd1;
    end
  end

  assign locked        = (state_q == LOCKED) || (state_q == ERROR);
  assign error         = (state_q == ERROR);
  assign idle          = (idle_cnt_q == IDLE_MAX);
  assign word_count    = word_q;
  assign error_count   = errc_q;
  assign first_err_exp = fexp_q;
  assign first_err_rcv = frcv_q;

endmodule

// File: tb/tb_io_stream_checker.sv
module tb_io_stream_checker;

  localparam int WIDTH       = 16;
  localparam int CNT_WIDTH   = 9;
  localparam int IDLE_CYCLES = 256;
  localparam int SEED        = 'hACE1;
  localparam int CNT_MAX     = (1 << CNT_WIDTH) - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [WIDTH-1:0]     fifo_in_data;
  logic                 fifo_in_valid;
  logic                 fifo_in_ready;
  logic                 stall_en;
  logic                 clear;
  logic                 locked;
  logic                 error;
  logic                 idle;
  logic [CNT_WIDTH-1:0] word_count;
  logic [CNT_WIDTH-1:0] error_count;
  logic [WIDTH-1:0]     first_err_exp;
  logic [WIDTH-1:0]     first_err_rcv;

  io_stream_checker #(
    .WIDTH      (WIDTH),
    .CNT_WIDTH  (CNT_WIDTH),
    .LFSR_SEED  (16'hACE1),
    .IDLE_CYCLES(IDLE_CYCLES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_in_data (fifo_in_data),
    .fifo_in_valid(fifo_in_valid),
    .fifo_in_ready(fifo_in_ready),
    .stall_en     (stall_en),
    .clear        (clear),
    .locked       (locked),
    .error        (error),
    .idle         (idle),
    .word_count   (word_count),
    .error_count  (error_count),
    .first_err_exp(first_err_exp),
    .first_err_rcv(first_err_rcv)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state (plain integers, spec-level view)
  int m_lfsr;
  bit m_stall;
  bit m_in_reset_cycle;
  bit m_synced;
  bit m_err;
  int m_exp;
  int m_words;
  int m_errs;
  int m_fexp;
  int m_frcv;
  int m_since;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic int lfsr_step(input int l);
    int b;
    b = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
    return ((l >> 1) | (b << 15)) & 'hFFFF;
  endfunction

  function automatic int sat(input int v);
    return (v < CNT_MAX) ? v + 1 : CNT_MAX;
  endfunction

  function automatic bit m_ready();
    return !m_in_reset_cycle && !m_stall;
  endfunction

  task automatic model_reset();
    m_lfsr = SEED; m_stall = 0; m_in_reset_cycle = 1;
    m_synced = 0; m_err = 0; m_exp = 0;
    m_words = 0; m_errs = 0; m_fexp = 0; m_frcv = 0; m_since = 0;
  endtask

  task automatic model_word(input int d);
    m_words = sat(m_words);
    if (!m_synced) begin
      m_synced = 1;
      m_exp = (d + 1) & 'hFFFF;
    end else if (d == m_exp) begin
      m_exp = (m_exp + 1) & 'hFFFF;
    end else begin
      if (m_errs == 0) begin
        m_fexp = m_exp;
        m_frcv = d;
      end
      m_errs = sat(m_errs);
      m_err = 1;
      m_exp = (d + 1) & 'hFFFF;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".locked"},  64'(locked),        64'(m_synced));
    check({tag, ".error"},   64'(error),         64'(m_err));
    check({tag, ".words"},   64'(word_count),    64'(m_words));
    check({tag, ".errs"},    64'(error_count),   64'(m_errs));
    check({tag, ".fexp"},    64'(first_err_exp), 64'(m_fexp));
    check({tag, ".frcv"},    64'(first_err_rcv), 64'(m_frcv));
    check({tag, ".idle"},    64'(idle),          64'(m_since >= IDLE_CYCLES));
  endtask

  // One clock: predict the transfer, advance the clock, then update the model.
  task automatic step();
    bit xf;
    int d;
    check("ready", 64'(fifo_in_ready), 64'(m_ready()));
    xf = fifo_in_valid && m_ready();
    d  = int'(fifo_in_data);
    @(posedge clk);
    #1;
    if (clear) begin
      m_synced = 0; m_err = 0; m_exp = 0;
      m_words = 0; m_errs = 0; m_fexp = 0; m_frcv = 0;
    end else if (xf) begin
      model_word(d);
    end
    if (xf || clear) m_since = 0;
    else m_since++;
    m_stall = stall_en && ((m_lfsr & 3) == 0);
    m_lfsr = lfsr_step(m_lfsr);
    m_in_reset_cycle = 0;
  endtask

  // Hold a word on the bus until it is accepted (bounded).
  task automatic send(input int d);
    bit acc;
    bit done;
    fifo_in_valid = 1'b1;
    fifo_in_data  = 16'(d);
    done = 0;
    for (int k = 0; k < 64 && !done; k++) begin
      acc = m_ready();
      step();
      if (acc) done = 1;
    end
    if (!done) check("send_timeout", 64'(0), 64'(1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fifo_in_valid = 1'b0;
    clear = 1'b0;
    #1;
    model_reset();
    check("rst.ready", 64'(fifo_in_ready), 64'(0));
    check_outputs("rst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int low_cnt;
    int nxt;
    int acc_cnt;
    rst = 1'b1;
    fifo_in_data = '0;
    fifo_in_valid = 1'b0;
    stall_en = 1'b0;
    clear = 1'b0;

    // Scenario 1: 0x0010..0x001F back-to-back, no stalls
    do_reset();
    step();
    check("s1.pre_lock", 64'(locked), 64'(0));
    send('h10);
    check("s1.lock_latency", 64'(locked), 64'(1));
    for (int i = 1; i < 16; i++) send('h10 + i);
    fifo_in_valid = 1'b0;
    check("s1.words", 64'(word_count), 64'(16));
    check("s1.errs", 64'(error_count), 64'(0));
    check("s1.error", 64'(error), 64'(0));
    check_outputs("s1");

    // Scenario 2: wrap-around 0xFFFE, 0xFFFF, 0x0000, 0x0001
    do_reset();
    send('hFFFE); send('hFFFF); send('h0000); send('h0001);
    fifo_in_valid = 1'b0;
    check("s2.words", 64'(word_count), 64'(4));
    check("s2.error", 64'(error), 64'(0));
    check_outputs("s2");

    // Scenario 3: 5,6,9,10,12 -> two mismatches
    do_reset();
    send(5); send(6); send(9); send(10); send(12);
    fifo_in_valid = 1'b0;
    check("s3.errs", 64'(error_count), 64'(2));
    check("s3.fexp", 64'(first_err_exp), 64'(7));
    check("s3.frcv", 64'(first_err_rcv), 64'(9));
    check("s3.error", 64'(error), 64'(1));
    check("s3.locked", 64'(locked), 64'(1));
    check("s3.words", 64'(word_count), 64'(5));
    check_outputs("s3");

    // Clear together with a transfer of 0x0055, then relock on 0x0100
    clear = 1'b1;
    fifo_in_valid = 1'b1;
    fifo_in_data = 16'h0055;
    step();
    clear = 1'b0;
    fifo_in_valid = 1'b0;
    check("clr.locked", 64'(locked), 64'(0));
    check("clr.error", 64'(error), 64'(0));
    check("clr.words", 64'(word_count), 64'(0));
    check("clr.fexp", 64'(first_err_exp), 64'(0));
    check_outputs("clr");
    send('h0100);
    send('h0101);
    fifo_in_valid = 1'b0;
    check("clr.relock", 64'(locked), 64'(1));
    check("clr.relock_words", 64'(word_count), 64'(2));
    check_outputs("relock");

    // Backpressure: valid held high 1000 cycles with the correct pattern
    stall_en = 1'b1;
    do_reset();
    low_cnt = 0;
    acc_cnt = 0;
    nxt = 'h2000;
    fifo_in_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      fifo_in_data = 16'(nxt);
      if (!fifo_in_ready) low_cnt++;
      if (m_ready()) begin
        nxt = (nxt + 1) & 'hFFFF;
        acc_cnt++;
      end
      step();
    end
    fifo_in_valid = 1'b0;
    check("stall.ratio_ok", 64'(low_cnt >= 200 && low_cnt <= 300), 64'(1));
    check("stall.errs", 64'(error_count), 64'(0));
    check("stall.words_sat", 64'(word_count), 64'((acc_cnt < CNT_MAX) ? acc_cnt : CNT_MAX));
    check_outputs("stall");

    // Randomised traffic: mostly correct data, random valid/stall/clear
    for (int i = 0; i < 600; i++) begin
      stall_en = ($urandom_range(0, 3) != 0);
      fifo_in_valid = 1'($urandom_range(0, 1));
      clear = ($urandom_range(0, 63) == 0);
      if (m_synced && $urandom_range(0, 7) != 0) fifo_in_data = 16'(m_exp);
      else fifo_in_data = 16'($urandom);
      step();
      check_outputs($sformatf("rand%0d", i));
    end
    clear = 1'b0;
    stall_en = 1'b0;

    // Error counter saturation with random data
    do_reset();
    fifo_in_valid = 1'b1;
    for (int i = 0; i < 600; i++) begin
      fifo_in_data = 16'($urandom);
      step();
    end
    fifo_in_valid = 1'b0;
    check("sat.errs", 64'(error_count), 64'(CNT_MAX));
    check("sat.words", 64'(word_count), 64'(CNT_MAX));
    check_outputs("sat");

    // Idle detection and asynchronous reset mid-stream
    do_reset();
    for (int i = 0; i < IDLE_CYCLES - 1; i++) step();
    check("idle.early", 64'(idle), 64'(0));
    step();
    check("idle.rise", 64'(idle), 64'(1));
    check_outputs("idle");
    send('h0040);
    check("idle.drop", 64'(idle), 64'(0));
    send('h0041); send('h0042);
    #1;
    rst = 1'b1;
    #2;
    check("arst.ready", 64'(fifo_in_ready), 64'(0));
    check("arst.locked", 64'(locked), 64'(0));
    check("arst.error", 64'(error), 64'(0));
    check("arst.idle", 64'(idle), 64'(0));
    check("arst.words", 64'(word_count), 64'(0));
    check("arst.errs", 64'(error_count), 64'(0));
    check("arst.fexp", 64'(first_err_exp), 64'(0));
    check("arst.frcv", 64'(first_err_rcv), 64'(0));
    fifo_in_valid = 1'b0;
    do_reset();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/io_stream_checker.md
Name: io_stream_checker

Overview:
- Consumer on the Host->Logic GLIP FIFO interface (fifo_in_*). Receives the stream from the FX3 toplevel in the logic clock domain and checks it against an incrementing-counter pattern.
- Injects pseudo-random backpressure to exercise FIFO and clock-domain-crossing flow control.
- Exposes lock/error/idle status plus word and error counters for LEDs and debug.

Parameters:
- WIDTH, 16, data word width; matches the GLIP FIFO width.
- CNT_WIDTH, 32, width of the word and error counters.
- LFSR_SEED, 16'hACE1, reset value of the stall LFSR; must be nonzero.
- IDLE_CYCLES, 256, consecutive cycles without a transfer before idle asserts; range 2..65535.

Ports:
- clk  in  1  logic clock; all state on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- fifo_in_data  in  WIDTH  Host->Logic data.
- fifo_in_valid  in  1  data valid.
- fifo_in_ready  out  1  checker can accept a word.
- stall_en  in  1  enables LFSR backpressure.
- clear  in  1  synchronous clear of checker state and counters.
- locked  out  1  checker is synchronised to the pattern.
- error  out  1  sticky; at least one mismatch since the last clear/reset.
- idle  out  1  no transfer for IDLE_CYCLES cycles.
- word_count  out  CNT_WIDTH  accepted words checked.
- error_count  out  CNT_WIDTH  mismatches detected.
- first_err_exp  out  WIDTH  expected value at the first mismatch.
- first_err_rcv  out  WIDTH  received value at the first mismatch.

Behaviour:
- Transfer: xfer = fifo_in_valid & fifo_in_ready, sampled at the rising edge. Data is consumed only on xfer.
- fifo_in_ready = ~rst_q & ~stall_q.
  - rst_q: register set asynchronously by rst, cleared on the first clk edge after rst deasserts. Ready is therefore 0 during reset and in that first cycle.
  - stall_q: registered, 0 at reset.
- Stall LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11, shifts every cycle; reset value LFSR_SEED.
  - Next stall_q = stall_en & (lfsr[1:0] == 2'b00), about 25% stall.
  - stall_en = 0 gives stall_q = 0 from the next cycle.
  - clear does not affect the LFSR.
- State machine (reset state HUNT):
  - HUNT: on xfer, exp <= data + 1; word_count++; go to LOCKED. No compare.
  - LOCKED: on xfer, compare data with exp.
    - Match: exp <= exp + 1.
    - Mismatch: error_count++; exp <= data + 1 (resync); go to ERROR.
    - If error_count == 0 before the increment, capture first_err_exp <= exp and first_err_rcv <= data.
    - word_count++ either way.
  - ERROR: same compare/count/resync as LOCKED; stays in ERROR. Later mismatches never overwrite first_err_*.
  - Any state with clear = 1: go to HUNT; counters, first_err_* and exp go to 0. A transfer in the same cycle is accepted (ready unaffected) but not checked or counted. clear has priority over everything except rst.
- Outputs:
  - locked = 1 in LOCKED or ERROR.
  - error = 1 in ERROR.
  - All outputs are registered state decodes, updated the cycle after the causing transfer.
- Arithmetic:
  - exp increments modulo 2^WIDTH; 0xFFFF followed by 0x0000 is a match.
  - word_count and error_count saturate at all-ones and do not wrap.
- Idle:
  - Counter is 0 at reset; resets to 0 on xfer or clear; otherwise increments, saturating at IDLE_CYCLES.
  - idle = (counter == IDLE_CYCLES), registered.
  - idle is 0 at reset and asserts IDLE_CYCLES cycles after the last transfer, or after reset if no transfer occurs.
- Reset mid-operation: every register returns to its reset value immediately (asynchronous). Reset values:
  - fifo_in_ready = 0, locked = 0, error = 0, idle = 0.
  - word_count = 0, error_count = 0, first_err_exp = 0, first_err_rcv = 0.
  - Internal: exp = 0, state = HUNT, lfsr = LFSR_SEED.
- Valid held with ready low: no state change; data must stay stable by GLIP convention and is not checked here.

Test Plan:
- Reset, stall_en = 0, then stream 0x0010..0x001F back-to-back -> locked = 1 one cycle after the first word; word_count = 16, error_count = 0, error = 0.
- Stream 0xFFFE, 0xFFFF, 0x0000, 0x0001 -> no error; word_count = 4 (wrap accepted).
- Stream 5, 6, 9, 10, 12 -> error_count = 2, first_err_exp = 7, first_err_rcv = 9, error = 1, locked = 1, word_count = 5.
- stall_en = 1, valid held high for 1000 cycles with a correct pattern -> fifo_in_ready low in roughly 200..300 cycles and sequence identical to an LFSR reference model; zero errors; word_count equals the number of xfer cycles.
- After the error scenario, pulse clear together with valid = 1 carrying data 0x0055 -> state HUNT, counters 0, that word not counted, error = 0, locked = 0; the next word 0x0100 locks.
- No traffic after reset with IDLE_CYCLES = 256 -> idle rises at cycle 256; one transfer drops it the next cycle; assert rst mid-stream -> all outputs zero without a clock edge.
